// File: rtl/fan_pwm_pkg.sv
// fan_pwm shared definitions: CSR layout, SCALE encoding
// and the period helper used by the counter wrap compare.
package fan_pwm_pkg;

  localparam logic [4:0] CTRL_OFS = 5'd0;
  localparam logic [4:0] DUTY_OFS = 5'd1;

  localparam int CTRL_EN_BIT   = 7;
  localparam int CTRL_KICK_BIT = 6;
  localparam int CTRL_SCALE_HI = 1;
  localparam int CTRL_SCALE_LO = 0;

  typedef enum logic [1:0] {
    SCALE_128 = 2'b00,
    SCALE_64  = 2'b01,
    SCALE_32  = 2'b10,
    SCALE_16  = 2'b11
  } scale_e;

  function automatic logic [2:0] wrap_bit(
    input scale_e s
  );
    logic [2:0] b;
    b = 3'd7;
    unique case (s)
      SCALE_128: b = 3'd7;
      SCALE_64:  b = 3'd6;
      SCALE_32:  b = 3'd5;
      SCALE_16:  b = 3'd4;
    endcase
    return b;
  endfunction

  // Last counter value of a period: P-1 with P = 1 << wrap bit
  function automatic logic [7:0] period_last(
    input scale_e s
  );
    logic [8:0] p;
    p = 9'd1 << wrap_bit(s);
    return p[7:0] - 8'd1;
  endfunction

endpackage

// File: rtl/fan_pwm_core.sv
// fan_pwm period counter, double-buffered duty/scale shadows
// and the registered compare that drives the pin.
module fan_pwm_core
  import fan_pwm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ce,
  input  logic       i_en,
  input  logic       i_en_nx,
  input  logic       i_start,
  input  logic       i_kick,
  input  logic [7:0] i_duty_nx,
  input  scale_e     i_scale_nx,
  output logic       o_wrap,
  output logic       o_pwm
);

  logic [7:0] r_cnt;
  logic [7:0] r_sduty;
  scale_e     r_sscale;
  logic       r_pwm;
  logic       w_last;

  assign w_last = (r_cnt == period_last(r_sscale));
  assign o_wrap = i_ce & i_en & w_last;
  assign o_pwm  = r_pwm;

  // Shadows load from the next-cycle register values so a
  // write landing on the wrap edge is taken by the new period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= 8'd0;
      r_sduty  <= 8'd0;
      r_sscale <= SCALE_128;
      r_pwm    <= 1'b0;
    end else if (!i_en_nx) begin
      r_cnt <= 8'd0;
      r_pwm <= 1'b0;
    end else if (i_start) begin
      r_cnt    <= 8'd0;
      r_sduty  <= i_duty_nx;
      r_sscale <= i_scale_nx;
      r_pwm    <= 1'b0;
    end else if (i_ce) begin
      r_pwm <= i_kick | (r_cnt < r_sduty);
      if (w_last) begin
        r_cnt    <= 8'd0;
        r_sduty  <= i_duty_nx;
        r_sscale <= i_scale_nx;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/fan_pwm.sv
// fan_pwm top: CSR decode, CTRL/DUTY registers, kick-start.
// Kick-start logic is built only with FAN_PWM_KICKSTART_EN.
module fan_pwm
  import fan_pwm_pkg::*;
#(
  parameter logic [4:0] BASE_ADDR    = 5'h0,
  parameter int         KICK_PERIODS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  input  logic       ce_pwm,
  output logic       pwm_out
);

  localparam logic [4:0] CTRL_A = BASE_ADDR + CTRL_OFS;
  localparam logic [4:0] DUTY_A = BASE_ADDR + DUTY_OFS;

  logic       r_en;
  scale_e     r_scale;
  logic [7:0] r_duty;

  logic       w_sel_ctrl;
  logic       w_sel_duty;
  logic       w_wr_ctrl;
  logic       w_wr_duty;
  logic       w_en_nx;
  scale_e     w_scale_nx;
  logic [7:0] w_duty_nx;
  logic       w_start;
  logic       w_wrap;
  logic       w_kick;

  assign w_sel_ctrl = (csr_a == CTRL_A);
  assign w_sel_duty = (csr_a == DUTY_A);
  assign w_wr_ctrl  = csr_we & w_sel_ctrl;
  assign w_wr_duty  = csr_we & w_sel_duty;

  assign w_en_nx = w_wr_ctrl ? csr_di[CTRL_EN_BIT] : r_en;
  assign w_scale_nx = w_wr_ctrl ?
    scale_e'(csr_di[CTRL_SCALE_HI:CTRL_SCALE_LO]) : r_scale;
  assign w_duty_nx = w_wr_duty ? csr_di : r_duty;
  assign w_start   = w_en_nx & ~r_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en    <= 1'b0;
      r_scale <= SCALE_128;
      r_duty  <= 8'd0;
    end else begin
      r_en    <= w_en_nx;
      r_scale <= w_scale_nx;
      r_duty  <= w_duty_nx;
    end
  end

`ifdef FAN_PWM_KICKSTART_EN
  logic [7:0] r_kick;

  // Counts remaining full-speed periods after spin-up
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kick <= 8'd0;
    end else if (!w_en_nx) begin
      r_kick <= 8'd0;
    end else if (w_start) begin
      r_kick <= 8'(KICK_PERIODS);
    end else if (w_wrap && (r_kick != 8'd0)) begin
      r_kick <= r_kick - 8'd1;
    end
  end

  assign w_kick = (r_kick != 8'd0);
`else
  logic w_unused_kick;
  assign w_unused_kick = (|KICK_PERIODS) ^ w_wrap;
  assign w_kick = 1'b0;
`endif

  always_comb begin
    csr_do = 8'd0;
    unique case (1'b1)
      w_sel_ctrl: begin
        csr_do[CTRL_EN_BIT]   = r_en;
        csr_do[CTRL_KICK_BIT] = w_kick;
        csr_do[CTRL_SCALE_HI:CTRL_SCALE_LO] = r_scale;
      end
      w_sel_duty: csr_do = r_duty;
      default:    csr_do = 8'd0;
    endcase
  end

  fan_pwm_core u_core (
    .clk        (clk),
    .rst        (rst),
    .i_ce       (ce_pwm),
    .i_en       (r_en),
    .i_en_nx    (w_en_nx),
    .i_start    (w_start),
    .i_kick     (w_kick),
    .i_duty_nx  (w_duty_nx),
    .i_scale_nx (w_scale_nx),
    .o_wrap     (w_wrap),
    .o_pwm      (pwm_out)
  );

endmodule

// File: tb/tb_fan_pwm.sv
// fan_pwm bench: expected pin levels queued per scenario,
// popped and compared one per clk on the falling edge.
module tb_fan_pwm;

  localparam logic [4:0] BASE   = 5'h08;
  localparam logic [4:0] CTRL_A = 5'h08;
  localparam logic [4:0] DUTY_A = 5'h09;
  localparam logic [4:0] OTHR_A = 5'h0A;

  logic       clk;
  logic       rst;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;
  logic       ce_pwm;
  logic       pwm_out;

  int n_chk;
  int n_fail;
  bit q_exp[$];
  bit q_kick[$];

  fan_pwm #(
    .BASE_ADDR    (BASE),
    .KICK_PERIODS (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .csr_a   (csr_a),
    .csr_di  (csr_di),
    .csr_we  (csr_we),
    .csr_do  (csr_do),
    .ce_pwm  (ce_pwm),
    .pwm_out (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst    = 1'b1;
    csr_we = 1'b0;
    ce_pwm = 1'b1;
    csr_a  = CTRL_A;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    csr_a  = a;
    csr_di = d;
    csr_we = 1'b1;
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  task automatic push_n(input bit v, input int n);
    repeat (n) q_exp.push_back(v);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    csr_we = 1'b0;
    ce_pwm = 1'b1;
    csr_di = 8'h00;
    csr_a  = CTRL_A;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_chk++;
    if (csr_do !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%h exp=00", csr_do);
    end
    csr_a = DUTY_A;
    #1;
    n_chk++;
    if (csr_do !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_duty got=%h exp=00", csr_do);
    end
    csr_a = OTHR_A;
    #1;
    n_chk++;
    if (csr_do !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_other got=%h exp=00", csr_do);
    end
    n_chk++;
    if (pwm_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pwm got=%b exp=0", pwm_out);
    end
  endtask

  task automatic test_csr();
    logic [7:0] exp_ctrl;
    do_reset();
    wr(DUTY_A, 8'hA5);
    wr(CTRL_A, 8'h7F);
    csr_a = DUTY_A;
    #1;
    n_chk++;
    if (csr_do !== 8'hA5) begin
      n_fail++;
      $display("FAIL csr_duty got=%h exp=a5", csr_do);
    end
    csr_a = CTRL_A;
    #1;
    n_chk++;
    if (csr_do !== 8'h03) begin
      n_fail++;
      $display("FAIL csr_ctrl got=%h exp=03", csr_do);
    end
    csr_a = OTHR_A;
    #1;
    n_chk++;
    if (csr_do !== 8'h00) begin
      n_fail++;
      $display("FAIL csr_other got=%h exp=00", csr_do);
    end
    csr_a = 5'h00;
    #1;
    n_chk++;
    if (csr_do !== 8'h00) begin
      n_fail++;
      $display("FAIL csr_addr0 got=%h exp=00", csr_do);
    end
    repeat (4) @(negedge clk);
    n_chk++;
    if (pwm_out !== 1'b0) begin
      n_fail++;
      $display("FAIL csr_pwm_off got=%b exp=0", pwm_out);
    end
`ifdef FAN_PWM_KICKSTART_EN
    exp_ctrl = 8'hC2;
`else
    exp_ctrl = 8'h82;
`endif
    wr(CTRL_A, 8'h82);
    csr_a = CTRL_A;
    #1;
    n_chk++;
    if (csr_do !== exp_ctrl) begin
      n_fail++;
      $display("FAIL csr_ctrl_en got=%h exp=%h", csr_do, exp_ctrl);
    end
  endtask

  task automatic test_duty32();
    bit e;
    do_reset();
    wr(DUTY_A, 8'd32);
    wr(CTRL_A, 8'h80);
    push_n(1'b0, 1);
    repeat (2) begin
      push_n(1'b1, 32);
      push_n(1'b0, 96);
    end
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      n_chk++;
      if (pwm_out !== e) begin
        n_fail++;
        $display("FAIL duty32 pwm got=%b exp=%b t=%0t", pwm_out, e, $time);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_const();
    bit e;
    do_reset();
    wr(DUTY_A, 8'd0);
    wr(CTRL_A, 8'h83);
    push_n(1'b0, 50);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      n_chk++;
      if (pwm_out !== e) begin
        n_fail++;
        $display("FAIL const_low pwm got=%b exp=%b t=%0t", pwm_out, e, $time);
      end
      @(negedge clk);
    end
    wr(CTRL_A, 8'h03);
    wr(DUTY_A, 8'hFF);
    wr(CTRL_A, 8'h83);
    push_n(1'b0, 1);
    push_n(1'b1, 50);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      n_chk++;
      if (pwm_out !== e) begin
        n_fail++;
        $display("FAIL const_high pwm got=%b exp=%b t=%0t", pwm_out, e, $time);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_duty();
    bit e;
    do_reset();
    wr(DUTY_A, 8'd32);
    wr(CTRL_A, 8'h80);
    push_n(1'b0, 1);
    push_n(1'b1, 32);
    push_n(1'b0, 96);
    push_n(1'b1, 64);
    push_n(1'b0, 64);
    for (int i = 0; q_exp.size() > 0; i++) begin
      e = q_exp.pop_front();
      n_chk++;
      if (pwm_out !== e) begin
        n_fail++;
        $display("FAIL mid_duty pwm got=%b exp=%b i=%0d", pwm_out, e, i);
      end
      if (i == 50) begin
        csr_a  = DUTY_A;
        csr_di = 8'd64;
        csr_we = 1'b1;
      end else begin
        csr_we = 1'b0;
      end
      @(negedge clk);
    end
    csr_we = 1'b0;
  endtask

  task automatic test_wrap_write();
    bit e;
    do_reset();
    wr(DUTY_A, 8'd4);
    wr(CTRL_A, 8'h83);
    push_n(1'b0, 1);
    push_n(1'b1, 4);
    push_n(1'b0, 12);
    repeat (2) begin
      push_n(1'b1, 10);
      push_n(1'b0, 6);
    end
    for (int i = 0; q_exp.size() > 0; i++) begin
      e = q_exp.pop_front();
      n_chk++;
      if (pwm_out !== e) begin
        n_fail++;
        $display("FAIL wrap_write pwm got=%b exp=%b i=%0d", pwm_out, e, i);
      end
      if (i == 14) begin
        csr_a  = DUTY_A;
        csr_di = 8'd10;
        csr_we = 1'b1;
      end else begin
        csr_we = 1'b0;
      end
      @(negedge clk);
    end
    csr_we = 1'b0;
  endtask

  task automatic test_disable();
    bit e;
    do_reset();
    wr(DUTY_A, 8'd32);
    wr(CTRL_A, 8'h80);
    push_n(1'b0, 1);
    push_n(1'b1, 9);
    push_n(1'b0, 6);
    push_n(1'b1, 32);
    push_n(1'b0, 4);
    for (int i = 0; q_exp.size() > 0; i++) begin
      e = q_exp.pop_front();
      n_chk++;
      if (pwm_out !== e) begin
        n_fail++;
        $display("FAIL disable pwm got=%b exp=%b i=%0d", pwm_out, e, i);
      end
      csr_a  = CTRL_A;
      csr_we = (i == 9) || (i == 14);
      csr_di = (i == 14) ? 8'h80 : 8'h00;
      @(negedge clk);
    end
    csr_we = 1'b0;
  endtask

  task automatic test_ce_hold();
    bit e;
    do_reset();
    wr(DUTY_A, 8'd4);
    wr(CTRL_A, 8'h83);
    push_n(1'b0, 1);
    push_n(1'b1, 9);
    push_n(1'b0, 2);
    for (int i = 0; q_exp.size() > 0; i++) begin
      e = q_exp.pop_front();
      n_chk++;
      if (pwm_out !== e) begin
        n_fail++;
        $display("FAIL ce_hold pwm got=%b exp=%b i=%0d", pwm_out, e, i);
      end
      if (i == 2) ce_pwm = 1'b0;
      if (i == 7) ce_pwm = 1'b1;
      csr_we = 1'b0;
      if (i == 4) begin
        csr_a  = DUTY_A;
        csr_di = 8'h33;
        csr_we = 1'b1;
      end
      if (i == 6) begin
        csr_a = DUTY_A;
        #1;
        n_chk++;
        if (csr_do !== 8'h33) begin
          n_fail++;
          $display("FAIL ce_hold_duty got=%h exp=33", csr_do);
        end
      end
      @(negedge clk);
    end
    csr_we = 1'b0;
    ce_pwm = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit e;
    do_reset();
    wr(DUTY_A, 8'd32);
    wr(CTRL_A, 8'h80);
    push_n(1'b0, 1);
    push_n(1'b1, 4);
    push_n(1'b0, 2);
    for (int i = 0; q_exp.size() > 0; i++) begin
      e = q_exp.pop_front();
      n_chk++;
      if (pwm_out !== e) begin
        n_fail++;
        $display("FAIL reset_mid pwm got=%b exp=%b i=%0d", pwm_out, e, i);
      end
      if (i == 4) rst = 1'b1;
      @(negedge clk);
    end
    rst   = 1'b0;
    csr_a = CTRL_A;
    #1;
    n_chk++;
    if (csr_do !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_ctrl got=%h exp=00", csr_do);
    end
    csr_a = DUTY_A;
    #1;
    n_chk++;
    if (csr_do !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_duty got=%h exp=00", csr_do);
    end
  endtask

`ifdef FAN_PWM_KICKSTART_EN
  task automatic test_kick();
    bit e;
    bit k;
    do_reset();
    wr(DUTY_A, 8'd4);
    wr(CTRL_A, 8'h83);
    csr_a = CTRL_A;
    push_n(1'b0, 1);
    push_n(1'b1, 36);
    push_n(1'b0, 12);
    push_n(1'b1, 4);
    push_n(1'b0, 12);
    for (int i = 0; i < 65; i++) q_kick.push_back(i < 32);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      k = q_kick.pop_front();
      #1;
      n_chk++;
      if (pwm_out !== e) begin
        n_fail++;
        $display("FAIL kick pwm got=%b exp=%b t=%0t", pwm_out, e, $time);
      end
      n_chk++;
      if (csr_do[6] !== k) begin
        n_fail++;
        $display("FAIL kick_bit got=%b exp=%b t=%0t", csr_do[6], k, $time);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    csr_a  = CTRL_A;
    csr_di = 8'h00;
    csr_we = 1'b0;
    ce_pwm = 1'b1;
    @(negedge clk);
    test_reset();
    test_csr();
    test_duty32();
    test_const();
    test_mid_duty();
    test_wrap_write();
    test_disable();
    test_ce_hold();
    test_reset_mid();
`ifdef FAN_PWM_KICKSTART_EN
    test_kick();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
